// File: rtl/mem_stage.sv
// Memory stage: registers the execute bus, extracts load data, drives write-back and decode forwarding buses.
// Outputs are combinational from bus_r (one cycle from ex_to_mem_bus); stall[3]/stall[4] hold or bubble, rbuf keeps SRAM data across holds.
module mem_stage #(
    parameter int EX_TO_MEM_WD = 146,
    parameter int MEM_TO_WB_WD = 136,
    parameter int MEM_TO_ID_WD = 104,
    parameter int STALL_WD     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus
);

    typedef struct packed {
        logic [3:0]  ld_type;
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_bus_t;

    localparam logic [3:0] LD_W  = 4'b1111;
    localparam logic [3:0] LD_B  = 4'b0001;
    localparam logic [3:0] LD_BU = 4'b0010;
    localparam logic [3:0] LD_H  = 4'b0011;
    localparam logic [3:0] LD_HU = 4'b0100;

    ex_bus_t     bus_r;
    logic [31:0] rbuf;
    logic        rbuf_vld;
    logic [31:0] rdata_sel;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;
    logic        load;
    logic        bubble;

    assign load   = !stall[3];
    assign bubble = stall[3] && !stall[4];

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            bus_r <= '0;
        end else if (load) begin
            bus_r <= ex_bus_t'(ex_to_mem_bus);
        end
    end

    // SRAM data is only valid in the first MEM cycle; capture it on the first hold edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rbuf     <= '0;
            rbuf_vld <= 1'b0;
        end else if (load || bubble) begin
            rbuf_vld <= 1'b0;
        end else if (!rbuf_vld) begin
            rbuf     <= data_sram_rdata;
            rbuf_vld <= 1'b1;
        end
    end

    assign rdata_sel = rbuf_vld ? rbuf : data_sram_rdata;

    always_comb begin
        byte_sel  = 8'h00;
        half_sel  = 16'h0000;
        load_data = 32'h0;
        case (bus_r.ex_result[1:0])
            2'b00:   byte_sel = rdata_sel[7:0];
            2'b01:   byte_sel = rdata_sel[15:8];
            2'b10:   byte_sel = rdata_sel[23:16];
            default: byte_sel = rdata_sel[31:24];
        endcase
        half_sel = bus_r.ex_result[1] ? rdata_sel[31:16] : rdata_sel[15:0];
        case (bus_r.ld_type)
            LD_W:    load_data = rdata_sel;
            LD_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   load_data = {24'h0, byte_sel};
            LD_H:    load_data = {{16{half_sel[15]}}, half_sel};
            LD_HU:   load_data = {16'h0, half_sel};
            default: load_data = 32'h0;
        endcase
    end

    assign rf_wdata = bus_r.sel_rf_res ? load_data : bus_r.ex_result;

    assign mem_to_wb_bus = {bus_r.hi_we, bus_r.lo_we, bus_r.hi, bus_r.lo, bus_r.pc,
                            bus_r.rf_we, bus_r.rf_waddr, rf_wdata};

    assign mem_to_id_bus = {bus_r.hi_we, bus_r.lo_we, bus_r.hi, bus_r.lo,
                            bus_r.rf_we, bus_r.rf_waddr, rf_wdata};

    logic unused_bits;
    assign unused_bits = ^{stall[2:0], stall[STALL_WD-1:5], bus_r.ram_en, bus_r.ram_wen};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed and random stimulus against an instruction-level model through a scoreboard queue.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [145:0] ex_bus;
    logic [31:0]  rdata;
    logic [135:0] wb_bus;
    logic [103:0] id_bus;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .ex_to_mem_bus  (ex_bus),
        .data_sram_rdata(rdata),
        .mem_to_wb_bus  (wb_bus),
        .mem_to_id_bus  (id_bus)
    );

    typedef struct {
        logic [135:0] wb;
        logic [103:0] id;
        logic         rvld;
        bit           has_k;
        logic [31:0]  k;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: the instruction currently resident in MEM and the SRAM word it saw on arrival.
    logic [145:0] m_instr;
    logic         m_held;
    logic [31:0]  m_saved;

    localparam logic [5:0] S_RUN  = 6'b000000;
    localparam logic [5:0] S_HOLD = 6'b011000;
    localparam logic [5:0] S_BUBL = 6'b001000;

    function automatic logic [145:0] mk(input logic [3:0] ld, input logic hw, input logic lw,
                                        input logic [31:0] hi, input logic [31:0] lo,
                                        input logic [31:0] pc, input logic ren, input logic [3:0] rwen,
                                        input logic sel, input logic we, input logic [4:0] wa,
                                        input logic [31:0] res);
        return {ld, hw, lw, hi, lo, pc, ren, rwen, sel, we, wa, res};
    endfunction

    function automatic logic [31:0] ld_model(input logic [3:0] t, input logic [31:0] rd, input logic [1:0] a);
        logic [31:0] b;
        logic [31:0] h;
        b = (rd >> (8 * int'(a))) & 32'h0000_00FF;
        h = (rd >> (a[1] ? 16 : 0)) & 32'h0000_FFFF;
        case (t)
            4'hF:    return rd;
            4'h1:    return b[7] ? (b | 32'hFFFF_FF00) : b;
            4'h2:    return b;
            4'h3:    return h[15] ? (h | 32'hFFFF_0000) : h;
            4'h4:    return h;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [135:0] exp_wb(input logic [145:0] ins, input logic [31:0] d);
        logic [31:0] wd;
        wd = ins[38] ? ld_model(ins[145:142], d, ins[1:0]) : ins[31:0];
        return {ins[141], ins[140], ins[139:108], ins[107:76], ins[75:44], ins[37], ins[36:32], wd};
    endfunction

    task automatic step(input logic r, input logic [5:0] s, input logic [145:0] e,
                        input logic [31:0] d, input bit hk, input logic [31:0] k);
        exp_t x;
        rst    = r;
        stall  = s;
        ex_bus = e;
        rdata  = d;
        x.wb    = exp_wb(m_instr, m_held ? m_saved : d);
        x.id    = {x.wb[135:70], x.wb[37:0]};
        x.rvld  = m_held;
        x.has_k = hk;
        x.k     = k;
        sb_q.push_back(x);
        @(posedge clk);
        if (r) begin
            m_instr = '0;
            m_held  = 1'b0;
        end else if (!s[3]) begin
            m_instr = e;
            m_held  = 1'b0;
        end else if (!s[4]) begin
            m_instr = '0;
            m_held  = 1'b0;
        end else if (!m_held) begin
            m_saved = d;
            m_held  = 1'b1;
        end
        #1;
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (sb_q.size() != 0) begin
            x = sb_q.pop_front();
            checks++;
            if (wb_bus !== x.wb) begin
                errors++;
                $display("FAIL wb_bus t=%0t actual=%h required=%h", $time, wb_bus, x.wb);
            end
            checks++;
            if (id_bus !== x.id) begin
                errors++;
                $display("FAIL id_bus t=%0t actual=%h required=%h", $time, id_bus, x.id);
            end
            checks++;
            if (dut.rbuf_vld !== x.rvld) begin
                errors++;
                $display("FAIL rbuf_vld t=%0t actual=%b required=%b", $time, dut.rbuf_vld, x.rvld);
            end
            if (x.has_k) begin
                checks++;
                if (wb_bus[31:0] !== x.k) begin
                    errors++;
                    $display("FAIL rf_wdata t=%0t actual=%h required=%h", $time, wb_bus[31:0], x.k);
                end
            end
        end
    end

    logic [3:0] ld_pool [10] = '{4'h0, 4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h6, 4'h9};
    logic [145:0] nop = '0;

    initial begin
        logic [145:0] rnd;
        logic [5:0]   s;
        int           r;
        rst    = 1'b1;
        stall  = S_RUN;
        ex_bus = '0;
        rdata  = 32'h0;
        m_instr = '0;
        m_held  = 1'b0;
        m_saved = '0;
        @(posedge clk);
        #1;

        // reset with nonzero inputs, including a hold request
        for (int i = 0; i < 3; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
            step(1'b1, (i == 1) ? S_HOLD : S_RUN, rnd, $urandom, 1'b1, 32'h0);
        end

        // lw from 0x1000
        step(1'b0, S_RUN, mk(4'hF, 0, 0, 0, 0, 32'h0040_0000, 1, 4'h0, 1, 1, 5'd8, 32'h1000), $urandom, 1'b0, 32'h0);
        step(1'b0, S_RUN, nop, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);

        // byte and halfword extraction
        step(1'b0, S_RUN, mk(4'h1, 0, 0, 0, 0, 32'h4, 1, 4'h0, 1, 1, 5'd9, 32'h1003), 32'h0, 1'b0, 32'h0);
        step(1'b0, S_RUN, mk(4'h2, 0, 0, 0, 0, 32'h8, 1, 4'h0, 1, 1, 5'd9, 32'h1003), 32'h8012_3456, 1'b1, 32'hFFFF_FF80);
        step(1'b0, S_RUN, mk(4'h3, 0, 0, 0, 0, 32'hC, 1, 4'h0, 1, 1, 5'd9, 32'h1002), 32'h8012_3456, 1'b1, 32'h0000_0080);
        step(1'b0, S_RUN, mk(4'h4, 0, 0, 0, 0, 32'h10, 1, 4'h0, 1, 1, 5'd9, 32'h1002), 32'h8001_7FFF, 1'b1, 32'hFFFF_8001);
        step(1'b0, S_RUN, nop, 32'h8001_7FFF, 1'b1, 32'h0000_8001);

        // lw held across a multi-cycle stall while SRAM data changes
        step(1'b0, S_RUN, mk(4'hF, 0, 0, 0, 0, 32'h20, 1, 4'h0, 1, 1, 5'd10, 32'h2000), 32'h0, 1'b0, 32'h0);
        step(1'b0, S_HOLD, nop, 32'h1111_1111, 1'b1, 32'h1111_1111);
        step(1'b0, S_HOLD, nop, 32'h2222_2222, 1'b1, 32'h1111_1111);
        step(1'b0, S_HOLD, nop, 32'h2222_2222, 1'b1, 32'h1111_1111);
        step(1'b0, S_RUN, mk(4'hF, 0, 0, 0, 0, 32'h24, 1, 4'h0, 1, 1, 5'd11, 32'h2004), 32'h2222_2222, 1'b1, 32'h1111_1111);
        step(1'b0, S_RUN, nop, 32'h3333_3333, 1'b1, 32'h3333_3333);

        // bubble, then an ALU result
        step(1'b0, S_BUBL, mk(4'hF, 1, 1, 5, 6, 32'h28, 1, 4'h0, 1, 1, 5'd12, 32'h0), 32'h5555_5555, 1'b0, 32'h0);
        step(1'b0, S_RUN, mk(4'h0, 0, 0, 0, 0, 32'h2C, 0, 4'h0, 0, 1, 5'd3, 32'h1234), 32'h6666_6666, 1'b1, 32'h0);
        step(1'b0, S_RUN, nop, 32'h7777_7777, 1'b1, 32'h1234);

        // hi/lo pass-through, then reset while holding
        step(1'b0, S_RUN, mk(4'h0, 1, 1, 32'hA, 32'hB, 32'h30, 0, 4'h0, 0, 0, 5'd0, 32'h0), 32'h0, 1'b0, 32'h0);
        step(1'b0, S_HOLD, nop, 32'h9999_9999, 1'b0, 32'h0);
        step(1'b0, S_HOLD, nop, 32'h8888_8888, 1'b0, 32'h0);
        step(1'b1, S_HOLD, nop, 32'h8888_8888, 1'b0, 32'h0);
        step(1'b0, S_HOLD, nop, 32'h8888_8888, 1'b1, 32'h0);
        step(1'b0, S_RUN, nop, 32'h0, 1'b1, 32'h0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)       s = S_RUN;
            else if (r < 7)  s = S_HOLD;
            else if (r < 8)  s = S_BUBL;
            else             s = 6'($urandom);
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
            rnd[145:142] = ld_pool[$urandom_range(0, 9)];
            step($urandom_range(0, 49) == 0, s, rnd, $urandom, 1'b0, 32'h0);
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
